light_monitor: RTL and testbench

Receiving end of the traffic-light controller's 2-bit state bus. Samples the encoded light state {Qa,Qb} and decodes it into the three lamp drives. Checks every transition against the legal sequence red→green→yellow→red and against per-colour minimum dwell times. On any violation it latches a fault and forces the fail-safe red aspect until software clears it.

---
 rtl/light_pkg.sv | 10 +
 rtl/light_blinker.sv | 30 +++
 rtl/light_monitor.sv | 130 +++++++++++++
 tb/tb_light_monitor.sv | 134 +++++++++++++
 4 files changed

// File: rtl/light_pkg.sv
// light_pkg: colour codes, FSM states, fault codes and the colour-sequence helper
// shared by light_monitor and light_blinker.
package light_pkg;
    localparam logic [1:0] RED = 2'b00, GREEN = 2'b01, YELLOW = 2'b10, BAD = 2'b11;
    localparam logic [1:0] FC_NONE = 2'd0, FC_CODE = 2'd1, FC_ORDER = 2'd2, FC_EARLY = 2'd3;
    typedef enum logic [1:0] {ST_INIT, ST_TRACK, ST_FAULT} state_t;
    function automatic logic [1:0] next_colour(input logic [1:0] c);
        return (c == RED) ? GREEN : (c == GREEN) ? YELLOW : RED;
    endfunction
endpackage

// File: rtl/light_blinker.sv
// light_blinker: square-wave level with half-period HALF; restart forces the level high
// and clears the phase, en advances the phase.
module light_blinker #(
    parameter int HALF = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic restart_i,
    input  logic en_i,
    output logic level_o
);
    localparam int W = (HALF > 1) ? $clog2(HALF) : 1;
    logic [W-1:0] cnt_q, cnt_d;
    logic level_q, level_d, wrap;
    assign wrap = cnt_q == W'(HALF - 1);
    always_comb begin
        cnt_d   = restart_i ? '0 : en_i ? (wrap ? '0 : cnt_q + 1'b1) : cnt_q;
        level_d = restart_i ? 1'b1 : (en_i && wrap) ? ~level_q : level_q;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            level_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end
    assign level_o = level_q;
endmodule

// File: rtl/light_monitor.sv
// light_monitor: decodes the 2-bit light state bus into lamp drives and latches sequence/dwell
// faults into a fail-safe red aspect. Define LIGHT_MON_BLINK_EN to blink red while faulted.
module light_monitor
    import light_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int MIN_RED    = 2,
    parameter int MIN_GREEN  = 2,
    parameter int MIN_YELLOW = 1,
    parameter int BLINK_HALF = 4
) (
    input  logic             CLK,
    input  logic             RES,
    input  logic             Qa,
    input  logic             Qb,
    input  logic             clr_fault,
    output logic             red,
    output logic             green,
    output logic             yellow,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] cycles
);
    state_t           state_q, state_d;
    logic [1:0]       code_q, cur_q, cur_d, fc_q, fc_d;
    logic             v_q, clr_q, blink;
    logic [CNT_W-1:0] dwell_q, dwell_d, cycles_q, cycles_d;

    if (BLINK_HALF < 1) begin : g_bad_half
        $error("BLINK_HALF must be at least 1");
    end

    function automatic logic [CNT_W-1:0] min_of(input logic [1:0] c);
        return (c == RED) ? CNT_W'(MIN_RED) : (c == GREEN) ? CNT_W'(MIN_GREEN) : CNT_W'(MIN_YELLOW);
    endfunction

    // v_q keeps the reset value of code_q from counting as a red sample
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            code_q <= RED;
            clr_q  <= 1'b0;
            v_q    <= 1'b0;
        end else begin
            code_q <= {Qa, Qb};
            clr_q  <= clr_fault;
            v_q    <= 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        dwell_d  = dwell_q;
        fc_d     = fc_q;
        cycles_d = cycles_q;
        case (state_q)
            ST_INIT: begin
                if (v_q && code_q == RED) begin
                    state_d = ST_TRACK;
                    cur_d   = RED;
                    dwell_d = CNT_W'(1);
                end else if (v_q && code_q == BAD) begin
                    state_d = ST_FAULT;
                    fc_d    = FC_CODE;
                end
            end
            ST_TRACK: begin
                if (code_q == cur_q) begin
                    dwell_d = (&dwell_q) ? dwell_q : dwell_q + 1'b1;
                end else if (code_q == BAD) begin
                    state_d = ST_FAULT;
                    fc_d    = FC_CODE;
                end else if (code_q != next_colour(cur_q)) begin
                    state_d = ST_FAULT;
                    fc_d    = FC_ORDER;
                end else if (dwell_q < min_of(cur_q)) begin
                    state_d = ST_FAULT;
                    fc_d    = FC_EARLY;
                end else begin
                    cur_d    = code_q;
                    dwell_d  = CNT_W'(1);
                    cycles_d = (cur_q == YELLOW) ? cycles_q + 1'b1 : cycles_q;
                end
            end
            default: begin
                if (clr_q && code_q == RED) begin
                    state_d = ST_TRACK;
                    cur_d   = RED;
                    dwell_d = CNT_W'(1);
                    fc_d    = FC_NONE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            state_q  <= ST_INIT;
            cur_q    <= RED;
            dwell_q  <= '0;
            fc_q     <= FC_NONE;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            dwell_q  <= dwell_d;
            fc_q     <= fc_d;
            cycles_q <= cycles_d;
        end
    end

`ifdef LIGHT_MON_BLINK_EN
    light_blinker #(.HALF(BLINK_HALF)) u_blinker (
        .clk_i    (CLK),
        .rst_ni   (RES),
        .restart_i(state_d == ST_FAULT && state_q != ST_FAULT),
        .en_i     (state_q == ST_FAULT),
        .level_o  (blink)
    );
`else
    assign blink = 1'b1;
`endif

    assign red        = (state_q == ST_FAULT) ? blink : (state_q == ST_INIT || cur_q == RED);
    assign green      = state_q == ST_TRACK && cur_q == GREEN;
    assign yellow     = state_q == ST_TRACK && cur_q == YELLOW;
    assign fault      = state_q == ST_FAULT;
    assign fault_code = fc_q;
    assign cycles     = cycles_q;
endmodule

// File: tb/tb_light_monitor.sv
// tb_light_monitor: directed vectors with hand-computed expectations for light_monitor
// (default build, steady red while faulted).
module tb_light_monitor;
    logic       CLK = 1'b0, RES = 1'b0, Qa = 1'b0, Qb = 1'b0, clr_fault = 1'b0;
    logic       red, green, yellow, fault;
    logic [1:0] fault_code;
    logic [7:0] cycles;
    int         n_chk = 0, n_fail = 0;

    light_monitor dut (
        .CLK(CLK), .RES(RES), .Qa(Qa), .Qb(Qb), .clr_fault(clr_fault),
        .red(red), .green(green), .yellow(yellow), .fault(fault),
        .fault_code(fault_code), .cycles(cycles)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // present one sample, let it be captured, then settle past the edge
    task automatic drive(input logic [1:0] c, input logic clr);
        {Qa, Qb}  = c;
        clr_fault = clr;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #2;
        check("reset_lamps", {red, green, yellow}, 3'b100);
        check("reset_fault", {fault, fault_code}, 3'b000);
        check("reset_cycles", cycles, 0);
        @(posedge CLK); #1;
        RES = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(2'b00, 1'b0);
            check("hold_red", {red, green, yellow, fault}, 4'b1000);
        end
        // legal sequence: red dwell reaches 3 before green is accepted
        drive(2'b01, 1'b0);
        drive(2'b01, 1'b0);
        check("seq_green", {red, green, yellow}, 3'b010);
        drive(2'b10, 1'b0);
        check("seq_green_hold", {red, green, yellow}, 3'b010);
        drive(2'b00, 1'b0);
        check("seq_yellow", {red, green, yellow}, 3'b001);
        drive(2'b00, 1'b0);
        check("seq_red", {red, green, yellow, fault}, 4'b1000);
        check("seq_cycles", cycles, 1);
        // illegal code while green
        drive(2'b00, 1'b0);
        drive(2'b01, 1'b0);
        drive(2'b11, 1'b0);
        check("pre_bad_green", green, 1);
        drive(2'b00, 1'b0);
        check("bad_fault", {fault, fault_code}, 3'b101);
        check("bad_lamps", {red, green, yellow}, 3'b100);
        for (int i = 0; i < 5; i++) begin
            drive(2'b00, 1'b0);
            check("bad_red_steady", {red, fault}, 2'b11);
        end
        drive(2'b00, 1'b1);
        drive(2'b00, 1'b0);
        check("clr1_fault", {fault, fault_code}, 3'b000);
        check("clr1_cycles", cycles, 1);
        // green held only one cycle before yellow
        drive(2'b00, 1'b0);
        drive(2'b01, 1'b0);
        drive(2'b10, 1'b0);
        drive(2'b11, 1'b0);
        check("early_code", {fault, fault_code}, 3'b111);
        drive(2'b00, 1'b0);
        check("early_held", fault_code, 3);
        drive(2'b00, 1'b1);
        drive(2'b00, 1'b0);
        check("clr2_fault", fault, 0);
        // red straight to yellow, then clears that must be ignored
        drive(2'b00, 1'b0);
        drive(2'b10, 1'b0);
        drive(2'b10, 1'b0);
        check("order_code", {fault, fault_code, red}, 4'b1101);
        drive(2'b10, 1'b1);
        drive(2'b10, 1'b0);
        check("clr_ignored", {fault, fault_code}, 3'b110);
        drive(2'b00, 1'b0);
        drive(2'b00, 1'b1);
        drive(2'b00, 1'b0);
        check("clr3_fault", {fault, fault_code}, 3'b000);
        check("clr3_lamps", {red, green, yellow}, 3'b100);
        check("clr3_cycles", cycles, 1);
        // wrap: each loop is one legal cycle, counted when the next red is accepted
        for (int i = 0; i < 255; i++) begin
            drive(2'b00, 1'b0);
            drive(2'b00, 1'b0);
            drive(2'b01, 1'b0);
            drive(2'b01, 1'b0);
            drive(2'b10, 1'b0);
        end
        check("wrap_255", cycles, 255);
        check("wrap_nofault", fault, 0);
        drive(2'b00, 1'b0);
        drive(2'b00, 1'b0);
        check("wrap_0", cycles, 0);
        check("wrap_red", {red, green, yellow, fault}, 4'b1000);
        drive(2'b01, 1'b0);
        drive(2'b01, 1'b0);
        check("mid_green", {red, green, yellow}, 3'b010);
        RES = 1'b0;
        #1;
        check("async_lamps", {red, green, yellow}, 3'b100);
        check("async_fault", {fault, fault_code}, 3'b000);
        @(posedge CLK); #1;
        RES = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(2'b01, 1'b0);
            check("init_wait", {red, green, yellow, fault}, 4'b1000);
        end
        drive(2'b00, 1'b0);
        drive(2'b00, 1'b0);
        drive(2'b00, 1'b0);
        drive(2'b01, 1'b0);
        drive(2'b01, 1'b0);
        check("post_reset_green", {red, green, yellow, fault}, 4'b0100);
        check("post_reset_cycles", cycles, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
